// File: rtl/reset_seq_pkg.sv
// Shared types for the board reset sequencer.
//   seq_state_t : sequencer phases, in release order.
//   cause_t     : encoding of reset_cause_o.
//   cnt_width() : bits needed to hold a counter that must reach max_count.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    CORE_UP   = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'd0,
    CAUSE_BUTTON = 2'd1,
    CAUSE_LOCK   = 2'd2,
    CAUSE_WDT    = 2'd3
  } cause_t;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_button_debouncer.sv
// Reset-button conditioner: 2-flop synchronizer followed by a stability filter.
// The debounced level flips only after the synchronized input has disagreed with
// it for DebounceCycles consecutive cycles; one agreeing cycle restarts the count.
// Ports:
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset (clears sync, counter, level)
//   button_i : raw button, active-high, asynchronous to clk_i
//   level_o  : debounced button level
//   press_o  : one-cycle pulse, registered together with the 0->1 flip of level_o
module button_debouncer
  import reset_seq_pkg::*;
#(
  parameter int unsigned DebounceCycles = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = cnt_width(DebounceCycles);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      // This cycle is the DebounceCycles-th disagreeing one: accept the new level.
      if (cnt_q == CntW'(DebounceCycles - 1)) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], button_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset generator. Qualifies PLL lock, debounces the reset button
// and releases a staged pair of resets: core first, peripherals PeriphDelayCycles
// later. The cause of the most recent reset and a saturating count of non-POR
// resets are kept until the next trigger or reset_i.
// Optional watchdog: define RESET_SEQ_WDT_EN to enable it (RUN only, cause 3).
// Without the macro wdt_kick_i is ignored.
// Ports:
//   clk_i         : system clock
//   reset_i       : asynchronous active-high block reset
//   pll_locked_i  : PLL lock, asynchronous to clk_i
//   button_i      : raw reset button, active-high, asynchronous
//   wdt_kick_i    : single-cycle watchdog kick
//   core_rst_o    : active-high reset to CPU core and bus
//   periph_rst_o  : active-high reset to peripherals
//   reset_cause_o : 0=POR 1=button 2=lock loss 3=watchdog
//   reset_count_o : non-POR resets, saturating at 255
//   state_o       : current sequencer phase (debug)
// Handshake: none; all outputs are registered levels, every input is sampled
// on each rising clk_i edge (async inputs through synchronizers first).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned FPGAClkSpeed      = 50000000,
  parameter int unsigned DebounceMs        = 10,
  parameter int unsigned LockFilterCycles  = 256,
  parameter int unsigned HoldCycles        = 1024,
  parameter int unsigned PeriphDelayCycles = 64,
  parameter int unsigned WdtTimeoutCycles  = 50000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       pll_locked_i,
  input  logic       button_i,
  input  logic       wdt_kick_i,
  output logic       core_rst_o,
  output logic       periph_rst_o,
  output logic [1:0] reset_cause_o,
  output logic [7:0] reset_count_o,
  output seq_state_t state_o
);

  localparam int unsigned DebounceCycles = FPGAClkSpeed / 1000 * DebounceMs;
  localparam int unsigned PhMaxLH = (LockFilterCycles > HoldCycles) ? LockFilterCycles : HoldCycles;
  localparam int unsigned PhMax   = (PhMaxLH > PeriphDelayCycles) ? PhMaxLH : PeriphDelayCycles;
  localparam int unsigned PhW     = cnt_width(PhMax);

  // ---------------------------------------------------------------- inputs
  logic [1:0] lock_sync_q;
  logic       lock_s;
  logic       press;
  logic       btn_level_unused;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) lock_sync_q <= 2'b00;
    else         lock_sync_q <= {lock_sync_q[0], pll_locked_i};
  end
  assign lock_s = lock_sync_q[1];

  button_debouncer #(
    .DebounceCycles(DebounceCycles)
  ) u_button_debouncer (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .button_i(button_i),
    .level_o (btn_level_unused),
    .press_o (press)
  );

  // ---------------------------------------------------------------- state
  seq_state_t     state_q;
  logic [PhW-1:0] phase_q, phase_nxt_d;
  logic           core_rst_q, periph_rst_q;
  cause_t         cause_q;
  logic [7:0]     count_q;
  logic           trig;
  cause_t         trig_cause;
  logic           wdt_timeout;

  assign phase_nxt_d = phase_q + 1'b1;

  // ---------------------------------------------------------------- watchdog
`ifdef RESET_SEQ_WDT_EN
  localparam int unsigned WdtW = cnt_width(WdtTimeoutCycles);
  logic [WdtW-1:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d = '0;
    if (state_q == RUN && !wdt_kick_i) wdt_d = wdt_q + 1'b1;
  end

  assign wdt_timeout = (state_q == RUN) && (wdt_d == WdtW'(WdtTimeoutCycles));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   wdt_q <= '0;
    else if (trig) wdt_q <= '0;
    else           wdt_q <= wdt_d;
  end
`else
  localparam int unsigned unused_wdt_timeout = WdtTimeoutCycles;
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick_i;
  assign wdt_timeout     = 1'b0;
`endif

  // ---------------------------------------------------------------- triggers
  // Only one cause per cycle: lock loss beats button beats watchdog.
  always_comb begin
    trig       = 1'b0;
    trig_cause = CAUSE_LOCK;
    if (state_q != WAIT_LOCK) begin
      if (!lock_s) begin
        trig       = 1'b1;
        trig_cause = CAUSE_LOCK;
      end else if (press) begin
        trig       = 1'b1;
        trig_cause = CAUSE_BUTTON;
      end else if (wdt_timeout) begin
        trig       = 1'b1;
        trig_cause = CAUSE_WDT;
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  // phase_q is shared: lock filter in WAIT_LOCK, hold timer in HOLD,
  // peripheral delay in CORE_UP. Each transition restarts it from zero, so the
  // two reset outputs can never release on the same edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= WAIT_LOCK;
      phase_q      <= '0;
      core_rst_q   <= 1'b1;
      periph_rst_q <= 1'b1;
      cause_q      <= CAUSE_POR;
      count_q      <= '0;
    end else if (trig) begin
      state_q      <= WAIT_LOCK;
      phase_q      <= '0;
      core_rst_q   <= 1'b1;
      periph_rst_q <= 1'b1;
      cause_q      <= trig_cause;
      if (count_q != 8'hFF) count_q <= count_q + 8'd1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          // A press while already in reset is remembered but not counted.
          if (press) begin
            cause_q <= CAUSE_BUTTON;
            phase_q <= '0;
          end else if (!lock_s) begin
            phase_q <= '0;
          end else if (phase_nxt_d == PhW'(LockFilterCycles)) begin
            state_q <= HOLD;
            phase_q <= '0;
          end else begin
            phase_q <= phase_nxt_d;
          end
        end
        HOLD: begin
          if (phase_nxt_d == PhW'(HoldCycles)) begin
            core_rst_q <= 1'b0;
            state_q    <= CORE_UP;
            phase_q    <= '0;
          end else begin
            phase_q <= phase_nxt_d;
          end
        end
        CORE_UP: begin
          if (phase_nxt_d == PhW'(PeriphDelayCycles)) begin
            periph_rst_q <= 1'b0;
            state_q      <= RUN;
            phase_q      <= '0;
          end else begin
            phase_q <= phase_nxt_d;
          end
        end
        RUN: begin
          phase_q <= '0;
        end
        default: begin
          state_q <= WAIT_LOCK;
          phase_q <= '0;
        end
      endcase
    end
  end

  assign core_rst_o    = core_rst_q;
  assign periph_rst_o  = periph_rst_q;
  assign reset_cause_o = cause_q;
  assign reset_count_o = count_q;
  assign state_o       = state_q;

endmodule
